pipe_stage_buf: RTL

//  Parametrised inter-stage pipeline buffer: successor of the single-bit valid/allowin stage register.

---
 rtl/pipe_stage_buf.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline buffer carrying a DATA_W payload
// through a DEPTH-entry circular queue. It uses a valid/allowin handshake,
// plus ready_go stall, synchronous flush and occupancy reporting.
// DEPTH=1 behaves as a classic single stage register.
// Optional feature: define PIPE_BUF_BYPASS_EN to allow an empty buffer to
// pass a beat combinationally from in_* to out_* with zero latency.
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_allowin,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_allowin,
   input  logic              ready_go,
   input  logic              flush,
   output logic [CNT_W-1:0]  count
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              not_empty;
   logic              bypass;
   logic              bypass_pass;
   logic              q_push;
   logic              q_pop;

   // Pointer increment with wrap at DEPTH-1, so DEPTH need not be a power of 2.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_P) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake outputs and queue push/pop qualifiers.
   always_comb begin
      not_empty = (count_q != '0);
`ifdef PIPE_BUF_BYPASS_EN
      bypass    = !not_empty && ready_go && in_valid && !flush;
`else
      bypass    = 1'b0;
`endif
      // A bypassed beat that is taken downstream never touches the queue.
      bypass_pass = bypass && out_allowin;
      out_valid   = (not_empty && ready_go) || bypass;
      out_data    = bypass ? in_data : mem_q[rd_ptr_q];
      in_allowin  = (count_q < DEPTH_C) || (ready_go && out_allowin);
      q_pop       = not_empty && ready_go && out_allowin;
      q_push      = in_valid && in_allowin && !bypass_pass;
      count       = count_q;
   end

   // Next-state for pointers and occupancy; flush overrides push and pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (q_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (q_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         case ({q_push, q_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage; not reset, written only on an accepted, non-flushed beat.
   always_ff @(posedge clk) begin
      if (q_push && !flush) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule
